// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter, drives a synchronous instruction memory
// (imem_en / pc_addr) and hands each returned word to decode over a
// valid/ready handshake. The memory's one-cycle read latency is absorbed
// without a skid buffer: the memory output register holds while imem_en=0,
// so a stalled instruction stays visible on instr_out.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap redirects whose
// target has redirect_pc[1:0] != 0. The trap halts fetch and raises a sticky
// fetch_misalign flag. Without the macro, the low two target bits are
// dropped and fetch_misalign is held at 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] pc_addr,
  input  logic [31:0] instr_out,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] redirect_tgt;
  logic        redirect_bad;
  logic        advance;

  // Redirect target conditioning: either flag misaligned targets or
  // silently force word alignment.
`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    redirect_tgt = redirect_pc;
    redirect_bad = redirect_en && (redirect_pc[1:0] != 2'b00);
  end
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    redirect_tgt = {redirect_pc[31:2], 2'b00};
    redirect_bad = 1'b0;
  end
`endif

  // Decode can take a new word when the IF slot is empty or being consumed.
  always_comb begin
    advance = !if_valid_q || id_ready;
  end

  // Next-state, memory request and IF-slot update.
  always_comb begin
    state_d    = state_q;
    imem_en    = 1'b0;
    pc_addr    = pc_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;

    case (state_q)
      ST_BOOT: begin
        // One idle cycle after reset; every input is ignored here.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect_en) begin
          // Redirect wins over halt and over a stall; the word now in IF
          // is dropped because the new fetch overwrites it, or because the
          // slot is cleared on a trapped target.
          pc_addr = redirect_tgt;
          if (redirect_bad) begin
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
            misalign_d = 1'b1;
          end else begin
            imem_en    = 1'b1;
            misalign_d = 1'b0;
          end
        end else if (halt_req) begin
          // Any pending accept still completes this edge; nothing new issues
          // and the slot empties.
          state_d    = ST_HALT;
          if_valid_d = 1'b0;
        end else if (advance) begin
          imem_en = 1'b1;
        end
        // Otherwise stalled: everything holds, including the memory output.
      end

      ST_HALT: begin
        // Only a redirect leaves HALT.
        pc_addr = redirect_tgt;
        if (redirect_en) begin
          if (redirect_bad) begin
            misalign_d = 1'b1;
          end else begin
            imem_en    = 1'b1;
            state_d    = ST_RUN;
            misalign_d = 1'b0;
          end
        end
      end

      default: begin
        state_d    = ST_BOOT;
        if_valid_d = 1'b0;
      end
    endcase

    // A memory read fills the IF slot on the next cycle.
    if (imem_en) begin
      pc_d       = pc_addr + 32'd4;
      if_pc_d    = pc_addr;
      if_valid_d = 1'b1;
    end
  end

  // State and IF-slot registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0000_0000;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = instr_out;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural synchronous memory
// returns a word derived from its address. Tests push the PCs that decode
// must accept into a queue, and a monitor pops and checks every handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_en;
  logic [31:0] pc_addr;
  logic [31:0] instr_out;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_misalign;

  // Second instance exercising PC wrap-around from the top of memory.
  logic        rst2_n;
  logic        imem_en2;
  logic [31:0] pc_addr2;
  logic [31:0] instr_out2;
  logic        redirect_en2;
  logic [31:0] redirect_pc2;
  logic        halt_req2;
  logic        if_valid2;
  logic        id_ready2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc2;
  logic        fetch_misalign2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .pc_addr(pc_addr),
    .instr_out(instr_out), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid), .id_ready(id_ready),
    .if_instr(if_instr), .if_pc(if_pc), .fetch_misalign(fetch_misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .imem_en(imem_en2), .pc_addr(pc_addr2),
    .instr_out(instr_out2), .redirect_en(redirect_en2), .redirect_pc(redirect_pc2),
    .halt_req(halt_req2), .if_valid(if_valid2), .id_ready(id_ready2),
    .if_instr(if_instr2), .if_pc(if_pc2), .fetch_misalign(fetch_misalign2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous instruction memory: output register updates only on a read.
  always @(posedge clk) begin
    if (imem_en) instr_out <= mem_word(pc_addr);
  end

  // Scoreboard monitor: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1 && redirect_en === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected: pc=%h instr=%h, required no accept", if_pc, if_instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== mem_word(e)) begin
          errors++;
          $display("FAIL accept: pc=%h instr=%h, required pc=%h instr=%h",
                   if_pc, if_instr, e, mem_word(e));
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; rst2_n = 1'b0;
    id_ready = 1'b1; redirect_en = 1'b0; halt_req = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_en !== 1'b0 || fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b pc=%h en=%b mis=%b, required 0 0 0 0",
               if_valid, if_pc, imem_en, fetch_misalign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_en !== 1'b0 || pc_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_cycle: en=%b addr=%h, required en=0 addr=0", imem_en, pc_addr);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) exp_q.push_back(32'(4 * (i - 1)));
      #1;
      checks++;
      if (imem_en !== 1'b1 || pc_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_issue%0d: en=%b addr=%h, required en=1 addr=%h", i, imem_en, pc_addr, 32'(4 * i));
      end
      checks++;
      if (i == 0) begin
        if (if_valid !== 1'b0) begin
          errors++;
          $display("FAIL seq_first_valid: valid=%b, required 0", if_valid);
        end
      end else if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1))) begin
        errors++;
        $display("FAIL seq_if_pc%0d: valid=%b pc=%h, required valid=1 pc=%h", i, if_valid, if_pc, 32'(4 * (i - 1)));
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_ready = 1'b0;
      #1;
      checks++;
      if (imem_en !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem_word(32'h8)) begin
        errors++;
        $display("FAIL stall%0d: en=%b valid=%b pc=%h instr=%h, required en=0 valid=1 pc=8 instr=%h",
                 i, imem_en, if_valid, if_pc, if_instr, mem_word(32'h8));
      end
    end
    @(negedge clk);
    exp_q.push_back(32'h8);
    id_ready = 1'b1;
    #1;
    checks++;
    if (imem_en !== 1'b1 || pc_addr !== 32'hC || if_pc !== 32'h8) begin
      errors++;
      $display("FAIL stall_release: en=%b addr=%h pc=%h, required en=1 addr=c pc=8", imem_en, pc_addr, if_pc);
    end
    @(negedge clk);
    exp_q.push_back(32'hC);
    #1;
    checks++;
    if (if_pc !== 32'hC || pc_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_resume: pc=%h addr=%h, required pc=c addr=10", if_pc, pc_addr);
    end
  endtask

  task automatic test_redirect;
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    checks++;
    if (if_pc !== 32'h10 || if_valid !== 1'b1 || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL redir_pre_stall: pc=%h valid=%b en=%b, required pc=10 valid=1 en=0", if_pc, if_valid, imem_en);
    end
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++;
    if (imem_en !== 1'b1 || pc_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_issue: en=%b addr=%h, required en=1 addr=40", imem_en, pc_addr);
    end
    @(negedge clk);
    redirect_en = 1'b0; id_ready = 1'b1;
    exp_q.push_back(32'h40);
    #1;
    checks++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1 || pc_addr !== 32'h44) begin
      errors++;
      $display("FAIL redir_target: pc=%h valid=%b addr=%h, required pc=40 valid=1 addr=44", if_pc, if_valid, pc_addr);
    end
    // Redirect while the current word would have been accepted: it is dropped.
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h80;
    #1;
    checks++;
    if (if_pc !== 32'h44 || imem_en !== 1'b1 || pc_addr !== 32'h80) begin
      errors++;
      $display("FAIL redir_accepting: pc=%h en=%b addr=%h, required pc=44 en=1 addr=80", if_pc, imem_en, pc_addr);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    exp_q.push_back(32'h80);
    #1;
    checks++;
    if (if_pc !== 32'h80 || pc_addr !== 32'h84) begin
      errors++;
      $display("FAIL redir_second: pc=%h addr=%h, required pc=80 addr=84", if_pc, pc_addr);
    end
  endtask

  task automatic test_halt;
    int bad;
    @(negedge clk);
    halt_req = 1'b1;
    exp_q.push_back(32'h84);
    #1;
    checks++;
    if (imem_en !== 1'b0 || if_pc !== 32'h84) begin
      errors++;
      $display("FAIL halt_req: en=%b pc=%h, required en=0 pc=84", imem_en, if_pc);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      halt_req = (i % 3 == 0);
      id_ready = i[0];
      #1;
      if (imem_en !== 1'b0 || if_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: %0d bad cycles, required 0", bad);
    end
    @(negedge clk);
    halt_req = 1'b0; id_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++;
    if (imem_en !== 1'b1 || pc_addr !== 32'h100) begin
      errors++;
      $display("FAIL halt_exit_issue: en=%b addr=%h, required en=1 addr=100", imem_en, pc_addr);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    exp_q.push_back(32'h100);
    #1;
    checks++;
    if (if_pc !== 32'h100 || if_valid !== 1'b1 || imem_en !== 1'b1 || pc_addr !== 32'h104) begin
      errors++;
      $display("FAIL halt_exit_run: pc=%h valid=%b en=%b addr=%h, required pc=100 valid=1 en=1 addr=104",
               if_pc, if_valid, imem_en, pc_addr);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    halt_req = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h20;
    #1;
    checks++;
    if (imem_en !== 1'b1 || pc_addr !== 32'h20) begin
      errors++;
      $display("FAIL simul_issue: en=%b addr=%h, required en=1 addr=20", imem_en, pc_addr);
    end
    @(negedge clk);
    halt_req = 1'b0; redirect_en = 1'b0;
    exp_q.push_back(32'h20);
    #1;
    checks++;
    if (if_pc !== 32'h20 || if_valid !== 1'b1 || imem_en !== 1'b1 || pc_addr !== 32'h24) begin
      errors++;
      $display("FAIL simul_run: pc=%h valid=%b en=%b addr=%h, required pc=20 valid=1 en=1 addr=24",
               if_pc, if_valid, imem_en, pc_addr);
    end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h22;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++;
    if (imem_en !== 1'b0) begin
      errors++;
      $display("FAIL mis_no_fetch: en=%b, required 0", imem_en);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    checks++;
    if (fetch_misalign !== 1'b1 || if_valid !== 1'b0 || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL mis_flag: mis=%b valid=%b en=%b, required 1 0 0", fetch_misalign, if_valid, imem_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fetch_misalign !== 1'b1 || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL mis_sticky: mis=%b en=%b, required 1 0", fetch_misalign, imem_en);
    end
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h24;
    #1;
    checks++;
    if (imem_en !== 1'b1 || pc_addr !== 32'h24 || fetch_misalign !== 1'b1) begin
      errors++;
      $display("FAIL mis_recover_issue: en=%b addr=%h mis=%b, required 1 24 1", imem_en, pc_addr, fetch_misalign);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    exp_q.push_back(32'h24);
    #1;
    checks++;
    if (if_pc !== 32'h24 || fetch_misalign !== 1'b0 || pc_addr !== 32'h28) begin
      errors++;
      $display("FAIL mis_recover: pc=%h mis=%b addr=%h, required 24 0 28", if_pc, fetch_misalign, pc_addr);
    end
`else
    checks++;
    if (imem_en !== 1'b1 || pc_addr !== 32'h20) begin
      errors++;
      $display("FAIL mis_aligned_issue: en=%b addr=%h, required en=1 addr=20", imem_en, pc_addr);
    end
    @(negedge clk);
    redirect_en = 1'b0;
    exp_q.push_back(32'h20);
    #1;
    checks++;
    if (if_pc !== 32'h20 || fetch_misalign !== 1'b0 || pc_addr !== 32'h24) begin
      errors++;
      $display("FAIL mis_aligned_run: pc=%h mis=%b addr=%h, required 20 0 24", if_pc, fetch_misalign, pc_addr);
    end
`endif
  endtask

  task automatic test_wrap;
    @(negedge clk);
    id_ready = 1'b0;
    rst2_n = 1'b1;
    #1;
    checks++;
    if (imem_en2 !== 1'b0 || pc_addr2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_boot: en=%b addr=%h, required en=0 addr=fffffffc", imem_en2, pc_addr2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (imem_en2 !== 1'b1 || pc_addr2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first: en=%b addr=%h, required en=1 addr=fffffffc", imem_en2, pc_addr2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pc_addr2 !== 32'h0 || if_pc2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_zero: addr=%h pc=%h, required addr=0 pc=fffffffc", pc_addr2, if_pc2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pc_addr2 !== 32'h4 || if_pc2 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: addr=%h pc=%h, required addr=4 pc=0", pc_addr2, if_pc2);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_en !== 1'b0 || fetch_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b pc=%h en=%b mis=%b, required 0 0 0 0",
               if_valid, if_pc, imem_en, fetch_misalign);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
  endtask

  initial begin
    instr_out    = 32'h0;
    instr_out2   = 32'h0;
    redirect_en2 = 1'b0;
    redirect_pc2 = 32'h0;
    halt_req2    = 1'b0;
    id_ready2    = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_simultaneous();
    test_misalign();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
